jk_counter_stage: RTL and testbench

//   Excitation stage plus a bank of JK storage cells forming a WIDTH-bit synchronous up/down counter.
//   Per-bit J/K drive is derived from the current state and the controls, then applied to a JK cell per bit.

---
 rtl/jk_counter_pkg.sv | 20 ++
 rtl/jk_counter_stage_jk_cell.sv | 29 ++
 rtl/jk_counter_stage.sv | 90 +++++++++
 tb/tb_jk_counter_stage.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/jk_counter_pkg.sv
// JK code type and excitation helper shared by the JK counter stage.
// Build option JK_COUNTER_MODULUS_EN is consumed by jk_counter_stage.
package jk_counter_pkg;

  typedef enum logic [1:0] {
    JK_HOLD   = 2'b00,
    JK_RESET  = 2'b01,
    JK_SET    = 2'b10,
    JK_TOGGLE = 2'b11
  } jk_t;

  function automatic jk_t jk_to(
    input logic cur,
    input logic tgt
  );
    if (cur == tgt) return JK_HOLD;
    return tgt ? JK_SET : JK_RESET;
  endfunction

endpackage

// File: rtl/jk_counter_stage_jk_cell.sv
// Single JK storage bit, async active-low reset to Q=0/QBar=1.
// Build option JK_COUNTER_MODULUS_EN has no effect here.
import jk_counter_pkg::*;

module jk_cell (
  input  logic Clock,
  input  logic ResetN,
  input  logic j,
  input  logic k,
  output logic q,
  output logic qbar
);

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      q <= 1'b0;
    end else begin
      case ({j, k})
        JK_HOLD:   q <= q;
        JK_RESET:  q <= 1'b0;
        JK_SET:    q <= 1'b1;
        default:   q <= ~q;
      endcase
    end
  end

  assign qbar = ~q;

endmodule

// File: rtl/jk_counter_stage.sv
// WIDTH-bit up/down counter built from per-bit JK excitation and cells.
// Define JK_COUNTER_MODULUS_EN to wrap at MODULUS instead of 2**WIDTH.
import jk_counter_pkg::*;

module jk_counter_stage #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             Clock,
  input  logic             ResetN,
  input  logic             Enable,
  input  logic             Up,
  input  logic             Load,
  input  logic [WIDTH-1:0] LoadValue,
  output logic [WIDTH-1:0] Count,
  output logic [WIDTH-1:0] CountBar,
  output logic             Wrap
);

`ifdef JK_COUNTER_MODULUS_EN
  localparam logic [WIDTH-1:0] TERM =
    WIDTH'(MODULUS - 1);
`else
  // MODULUS is deliberately masked out here
  localparam logic [WIDTH-1:0] TERM =
    WIDTH'((2**WIDTH - 1) | (MODULUS & 0));
`endif

  logic [1:0] code [WIDTH];
  logic       carry;
  logic       wrap_d;
  logic       wrap_q;

  always_comb begin
    wrap_d = 1'b0;
    carry  = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      code[i] = JK_HOLD;
    end
    if (Load) begin
      for (int i = 0; i < WIDTH; i++) begin
        code[i] = LoadValue[i] ? JK_SET : JK_RESET;
      end
    end else if (Enable) begin
      // bit i toggles when all lower bits are 1 (up) or 0 (down)
      for (int i = 0; i < WIDTH; i++) begin
        code[i] = carry ? JK_TOGGLE : JK_HOLD;
        carry   = carry & (Up ? Count[i] : ~Count[i]);
      end
      if (Up && Count >= TERM) begin
        wrap_d = 1'b1;
`ifdef JK_COUNTER_MODULUS_EN
        for (int i = 0; i < WIDTH; i++) begin
          code[i] = JK_RESET;
        end
`endif
      end
      if (!Up && Count == '0) begin
        wrap_d = 1'b1;
`ifdef JK_COUNTER_MODULUS_EN
        for (int i = 0; i < WIDTH; i++) begin
          code[i] = jk_to(Count[i], TERM[i]);
        end
`endif
      end
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    jk_cell u_cell (
      .Clock  (Clock),
      .ResetN (ResetN),
      .j      (code[i][1]),
      .k      (code[i][0]),
      .q      (Count[i]),
      .qbar   (CountBar[i])
    );
  end

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= wrap_d;
    end
  end

  assign Wrap = wrap_q;

endmodule

// File: tb/tb_jk_counter_stage.sv
// Scoreboard bench for jk_counter_stage (WIDTH=4, MODULUS=10).
// Define JK_COUNTER_MODULUS_EN to run the modulus vectors.
module tb_jk_counter_stage;

  logic       Clock;
  logic       ResetN;
  logic       Enable;
  logic       Up;
  logic       Load;
  logic [3:0] LoadValue;
  logic [3:0] Count;
  logic [3:0] CountBar;
  logic       Wrap;

  typedef struct {
    logic [3:0] c;
    logic       w;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   n_pop  = 0;
  event chk_ev;

  jk_counter_stage #(.WIDTH(4), .MODULUS(10)) dut (
    .Clock     (Clock),
    .ResetN    (ResetN),
    .Enable    (Enable),
    .Up        (Up),
    .Load      (Load),
    .LoadValue (LoadValue),
    .Count     (Count),
    .CountBar  (CountBar),
    .Wrap      (Wrap)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge Clock or chk_ev);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        n_pop++;
        n_chk++;
        if (Count !== e.c) begin
          n_fail++;
          $display("FAIL count #%0d got %h want %h",
                   n_pop, Count, e.c);
        end
        n_chk++;
        if (CountBar !== ~e.c) begin
          n_fail++;
          $display("FAIL countbar #%0d got %h want %h",
                   n_pop, CountBar, ~e.c);
        end
        n_chk++;
        if (Wrap !== e.w) begin
          n_fail++;
          $display("FAIL wrap #%0d got %b want %b",
                   n_pop, Wrap, e.w);
        end
      end
    end
  end

  task automatic step(
    input logic       ld,
    input logic [3:0] lv,
    input logic       en,
    input logic       up,
    input logic [3:0] ec,
    input logic       ew
  );
    @(negedge Clock);
    ResetN    = 1'b1;
    Load      = ld;
    LoadValue = lv;
    Enable    = en;
    Up        = up;
    sb.push_back('{c: ec, w: ew});
  endtask

  task automatic async_reset_check();
    @(negedge Clock);
    Load      = 1'b1;
    LoadValue = 4'h9;
    Enable    = 1'b1;
    #2;
    ResetN = 1'b0;
    #1;
    sb.push_back('{c: 4'h0, w: 1'b0});
    ->chk_ev;
    @(negedge Clock);
    step(1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0);
  endtask

  initial begin : stim
    ResetN    = 1'b0;
    Enable    = 1'b0;
    Up        = 1'b0;
    Load      = 1'b0;
    LoadValue = 4'h0;
    #3;
    sb.push_back('{c: 4'h0, w: 1'b0});
    ->chk_ev;
    step(1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0);

`ifndef JK_COUNTER_MODULUS_EN
    for (int i = 1; i < 16; i++) begin
      step(1'b0, 4'h0, 1'b1, 1'b1, 4'(i), 1'b0);
    end
    step(1'b0, 4'h0, 1'b1, 1'b1, 4'h0, 1'b1);
    step(1'b0, 4'h0, 1'b0, 1'b1, 4'h0, 1'b0);
    step(1'b0, 4'h0, 1'b1, 1'b0, 4'hF, 1'b1);
    step(1'b0, 4'h0, 1'b1, 1'b0, 4'hE, 1'b0);
    step(1'b1, 4'hA, 1'b1, 1'b1, 4'hA, 1'b0);
    step(1'b0, 4'h0, 1'b1, 1'b1, 4'hB, 1'b0);
    step(1'b0, 4'h0, 1'b1, 1'b0, 4'hA, 1'b0);
    step(1'b0, 4'h0, 1'b1, 1'b1, 4'hB, 1'b0);
    step(1'b1, 4'h6, 1'b0, 1'b0, 4'h6, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 4'h0, 1'b0, 1'(i), 4'h6, 1'b0);
    end
`else
    step(1'b1, 4'h8, 1'b0, 1'b0, 4'h8, 1'b0);
    step(1'b0, 4'h0, 1'b1, 1'b1, 4'h9, 1'b0);
    step(1'b0, 4'h0, 1'b1, 1'b1, 4'h0, 1'b1);
    step(1'b0, 4'h0, 1'b1, 1'b0, 4'h9, 1'b1);
    step(1'b0, 4'h0, 1'b1, 1'b0, 4'h8, 1'b0);
    step(1'b1, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0);
    step(1'b0, 4'h0, 1'b1, 1'b0, 4'h9, 1'b1);
    step(1'b0, 4'h0, 1'b0, 1'b0, 4'h9, 1'b0);
    step(1'b1, 4'hC, 1'b1, 1'b1, 4'hC, 1'b0);
    step(1'b0, 4'h0, 1'b1, 1'b1, 4'h0, 1'b1);
    step(1'b1, 4'hF, 1'b0, 1'b1, 4'hF, 1'b0);
    step(1'b0, 4'h0, 1'b1, 1'b1, 4'h0, 1'b1);
    step(1'b1, 4'h6, 1'b0, 1'b0, 4'h6, 1'b0);
`endif

    step(1'b0, 4'h0, 1'b1, 1'b1, 4'h7, 1'b0);
    async_reset_check();
    step(1'b0, 4'h0, 1'b1, 1'b1, 4'h1, 1'b0);

    for (int i = 0; i < 20 && sb.size() > 0; i++) begin
      @(negedge Clock);
    end
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain got %0d pending want 0",
               sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
